adder_pipelined: RTL and testbench

ADDER_PIPELINED -- requirements
Module: adder_pipelined

---
 rtl/adder_pipelined.sv | 107 ++++++++++
 tb/tb_adder_pipelined.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/adder_pipelined.sv
// Carry-pipelined adder/subtractor.
// Operands are registered in an input stage, then summed one SEG-bit segment
// per pipeline stage, the carry between segments travelling in a register.
// Upper operand segments ride along until their stage; finished lower sum
// segments ride along so the whole word lands in Sum_reg on one edge.
// Ports:
//   Clk, Rst_n          clock, asynchronous active-low reset
//   En                  pipeline advance enable (0 = every register holds)
//   In_valid            qualifies A, B, Cin, Sub this cycle
//   A, B                operands (WIDTH)
//   Cin                 carry-in for add; ignored for subtract
//   Sub                 0 = A+B+Cin, 1 = A-B
//   Sum_reg             registered result (WIDTH)
//   Carry_reg           registered MSB carry-out (subtract: 1 = no borrow)
//   Overflow_reg        registered two's-complement overflow
//   Out_valid           registered; result outputs are valid
module adder_pipelined #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic             In_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic [WIDTH-1:0] Sum_reg,
  output logic             Carry_reg,
  output logic             Overflow_reg,
  output logic             Out_valid
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned SEGW = SEG + 1;
  localparam int unsigned LAST = STAGES - 1;

  // r_a/r_b[j]: effective operands entering summing stage j+1 (j=0 is the input stage)
  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  // r_s[j]: sum with segments 0..j complete, lower bits only
  logic [WIDTH-1:0] r_s [STAGES];
  // r_c[0]: effective carry-in; r_c[j+1]: carry out of segment j
  logic             r_c [STAGES+1];
  logic             r_v [STAGES+1];
  logic             r_ovf;

  logic [SEG:0]     w_tot      [STAGES];
  logic [WIDTH-1:0] w_sum_next [STAGES];
  logic             w_ovf;

  // Per-stage segment adder and running sum assembly
  always_comb begin
    for (int j = 0; j < int'(STAGES); j++) begin
      w_tot[j] = {1'b0, SEG'(r_a[j] >> (j * SEG))}
               + {1'b0, SEG'(r_b[j] >> (j * SEG))}
               + SEGW'(r_c[j]);
    end
    w_sum_next[0] = WIDTH'(w_tot[0][SEG-1:0]);
    for (int j = 1; j < int'(STAGES); j++) begin
      w_sum_next[j] = r_s[j-1] | (WIDTH'(w_tot[j][SEG-1:0]) << (j * SEG));
    end
    // Same-sign operands producing an opposite-sign result; equals carry-in
    // XOR carry-out of the MSB
    w_ovf = (r_a[LAST][WIDTH-1] == r_b[LAST][WIDTH-1]) &&
            (w_tot[LAST][SEG-1] != r_a[LAST][WIDTH-1]);
  end

  // Pipeline registers: reset clears everything, En=0 freezes everything
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int j = 0; j < int'(STAGES); j++) begin
        r_a[j] <= '0;
        r_b[j] <= '0;
        r_s[j] <= '0;
      end
      for (int j = 0; j <= int'(STAGES); j++) begin
        r_c[j] <= 1'b0;
        r_v[j] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (En) begin
      // Subtract folds into A + ~B + 1
      r_a[0] <= A;
      r_b[0] <= Sub ? ~B : B;
      r_c[0] <= Sub ? 1'b1 : Cin;
      r_v[0] <= In_valid;
      for (int j = 0; j < int'(STAGES); j++) begin
        r_s[j]   <= w_sum_next[j];
        r_c[j+1] <= w_tot[j][SEG];
        r_v[j+1] <= r_v[j];
      end
      for (int j = 0; j + 1 < int'(STAGES); j++) begin
        r_a[j+1] <= r_a[j];
        r_b[j+1] <= r_b[j];
      end
      r_ovf <= w_ovf;
    end
  end

  assign Sum_reg      = r_s[LAST];
  assign Carry_reg    = r_c[STAGES];
  assign Overflow_reg = r_ovf;
  assign Out_valid    = r_v[STAGES];

endmodule

// File: tb/tb_adder_pipelined.sv
// Bench for adder_pipelined (WIDTH=8, STAGES=2): directed vectors, streaming,
// stall, mid-stream reset and randomized traffic against an arithmetic model.
module tb_adder_pipelined;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STAGES = 2;

  logic             Clk = 1'b0;
  logic             Rst_n;
  logic             En;
  logic             In_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic [WIDTH-1:0] Sum_reg;
  logic             Carry_reg;
  logic             Overflow_reg;
  logic             Out_valid;

  adder_pipelined #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .In_valid(In_valid),
    .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .Sum_reg(Sum_reg), .Carry_reg(Carry_reg),
    .Overflow_reg(Overflow_reg), .Out_valid(Out_valid)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       v;
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  exp_t q[$];   // operations captured but not yet at the outputs
  exp_t cur;    // what the outputs must show now
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views
  function automatic exp_t ref_op(input logic v, input logic [7:0] a, input logic [7:0] b,
                                  input logic cin, input logic sub);
    exp_t r;
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int full;
    int sr;
    if (sub) begin
      full = ua + (255 - ub) + 1;
      sr   = sa - sb;
    end else begin
      full = ua + ub + int'(cin);
      sr   = sa + sb + int'(cin);
    end
    r.v = v;
    r.s = full[7:0];
    r.c = full[8];
    r.o = (sr > 127) || (sr < -128);
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(Out_valid), 32'(cur.v));
    if (cur.v) begin
      check({tag, ".sum"}, 32'(Sum_reg), 32'(cur.s));
      check({tag, ".carry"}, 32'(Carry_reg), 32'(cur.c));
      check({tag, ".ovf"}, 32'(Overflow_reg), 32'(cur.o));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".sum"}, 32'(Sum_reg), 32'h0);
    check({tag, ".carry"}, 32'(Carry_reg), 32'h0);
    check({tag, ".ovf"}, 32'(Overflow_reg), 32'h0);
    check({tag, ".valid"}, 32'(Out_valid), 32'h0);
  endtask

  // One clock: drive at negedge, model the enabled edge, check 1 ns later
  task automatic cycle(input string tag, input logic en, input logic v,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub);
    @(negedge Clk);
    En = en; In_valid = v; A = a; B = b; Cin = cin; Sub = sub;
    @(posedge Clk);
    if (en) begin
      q.push_back(ref_op(v, a, b, cin, sub));
      if (q.size() > int'(STAGES)) cur = q.pop_front();
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic flush(input string tag);
    for (int i = 0; i < int'(STAGES) + 1; i++) cycle(tag, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic clear_model();
    q.delete();
    cur = '{v: 1'b0, s: 8'h00, c: 1'b0, o: 1'b0};
  endtask

  initial begin
    clear_model();
    Rst_n = 1'b0; En = 1'b0; In_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;

    // Directed arithmetic vectors
    cycle("ff_01", 1'b1, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
    flush("ff_01");
    check("ff_01.direct_sum", 32'(Sum_reg), 32'h00);
    cycle("0f_01", 1'b1, 1'b1, 8'h0F, 8'h01, 1'b0, 1'b0);
    cycle("7f_01", 1'b1, 1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
    cycle("0f_00c", 1'b1, 1'b1, 8'h0F, 8'h00, 1'b1, 1'b0);
    cycle("sub05_07", 1'b1, 1'b1, 8'h05, 8'h07, 1'b1, 1'b1);
    cycle("sub80_01", 1'b1, 1'b1, 8'h80, 8'h01, 1'b0, 1'b1);
    flush("directed");

    // Streaming with a bubble
    cycle("stream0", 1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    cycle("stream1", 1'b1, 1'b1, 8'hF0, 8'h20, 1'b1, 1'b0);
    cycle("stream2", 1'b1, 1'b0, 8'hAA, 8'h55, 1'b0, 1'b0);
    cycle("stream3", 1'b1, 1'b1, 8'h10, 8'h20, 1'b0, 1'b1);
    flush("stream");

    // Stall mid-stream
    cycle("stall_in0", 1'b1, 1'b1, 8'h81, 8'h81, 1'b0, 1'b0);
    cycle("stall_in1", 1'b1, 1'b1, 8'h40, 8'h40, 1'b0, 1'b0);
    cycle("stall_in2", 1'b1, 1'b1, 8'h01, 8'h02, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle("stall", 1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
    flush("stall_out");

    // Reset with two operations in flight
    cycle("rst_in0", 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
    cycle("rst_in1", 1'b1, 1'b1, 8'h7F, 8'h7F, 1'b0, 1'b0);
    @(negedge Clk);
    En = 1'b1; In_valid = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    clear_model();
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < int'(STAGES) + 3; i++)
      cycle("post_rst", 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Randomized traffic with random stalls
    for (int i = 0; i < 400; i++)
      cycle("rand", ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom));
    flush("rand_flush");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
